// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: feeds operand bits LSB-first to an external 1-bit slice and assembles the result.
// Latency: start accepted at edge N -> done during cycle N+WIDTH+1; one operation in flight, no queuing.
// Backpressure: start is honoured only in IDLE; while busy it is ignored. Optional zero flag under SERIAL_ALU_ZERO_EN.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_a,
  output logic             alu_b,
  output logic [2:0]       alu_o,
  input  logic             alu_c
`ifdef SERIAL_ALU_ZERO_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and status/slice outputs; slice inputs are forced low outside RUN.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    alu_a   = 1'b0;
    alu_b   = 1'b0;
    alu_o   = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        alu_a = a_sh[0];
        alu_b = b_sh[0];
        alu_o = op_q;
        if (last_bit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accepted start, then shift one bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      op_q   <= 3'b000;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            op_q   <= op;
            cnt    <= '0;
            result <= '0;
          end
        end
        S_RUN: begin
          result <= {alu_c, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SERIAL_ALU_ZERO_EN
  logic any_one;

  // Sticky OR of every result bit produced; cleared when a new operation starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_one <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      any_one <= 1'b0;
    end else if (state_q == S_RUN) begin
      any_one <= any_one | alu_c;
    end
  end

  assign zero = ~any_one;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl with a behavioural 1-bit slice stub.
// Compares per-cycle slice drive, done/busy timing and results against a word-level reference.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         alu_a;
  logic         alu_b;
  logic [2:0]   alu_o;
  logic         alu_c;
`ifdef SERIAL_ALU_ZERO_EN
  logic         zero;
`endif

  int n_cmp;
  int n_err;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_o  (alu_o),
    .alu_c  (alu_c)
`ifdef SERIAL_ALU_ZERO_EN
    ,
    .zero   (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice stub: 000 AND, 001 OR, 010 XOR, anything else passes A.
  always_comb begin
    alu_c = alu_a;
    case (alu_o)
      3'b000:  alu_c = alu_a & alu_b;
      3'b001:  alu_c = alu_a | alu_b;
      3'b010:  alu_c = alu_a ^ alu_b;
      default: alu_c = alu_a;
    endcase
  end

  // Word-level reference for a whole operation.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] o);
    case (o)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      default: return a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input logic [W-1:0] exp);
`ifdef SERIAL_ALU_ZERO_EN
    check("zero", zero, (exp == '0));
`else
    if (exp === 'x) $display("unused");
`endif
  endtask

  // One full operation from IDLE; poke pulses start during RUN (3rd cycle) and DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                        input bit poke);
    logic [W-1:0] exp;
    exp   = ref_alu(a, b, o);
    a_in  = a;
    b_in  = b;
    op    = o;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("alu_a", alu_a, a[i]);
      check("alu_b", alu_b, b[i]);
      check("alu_o", alu_o, o);
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      op    = 3'($urandom);
      start = poke && (i == 2);
      step();
    end
    start = 1'b0;
    check("done_pulse", done, 1);
    check("busy_done", busy, 1);
    check("result", result, exp);
    check_zero(exp);
    start = poke;
    step();
    start = 1'b0;
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("result_hold", result, exp);
    check("alu_o_idle", alu_o, 0);
    check("alu_a_idle", alu_a, 0);
    check("alu_b_idle", alu_b, 0);
    check_zero(exp);
    step();
    check("busy_idle2", busy, 0);
    check("result_hold2", result, exp);
  endtask

  initial begin
    int last_done;
    int n_done;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a_in  = '0;
    b_in  = '0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_alu_o", alu_o, 0);
    check("rst_alu_a", alu_a, 0);
    check_zero('0);
    rst = 1'b0;
    step();

    // Directed cases.
    run_op(8'hF0, 8'h3C, 3'b000, 1'b0);
    run_op(8'hAA, 8'h55, 3'b010, 1'b0);
    run_op(8'hAA, 8'h55, 3'b000, 1'b0);
    run_op(8'hF0, 8'h3C, 3'b000, 1'b1);

    // Reset in the middle of RUN discards the operation.
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    op    = 3'b001;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_alu_o", alu_o, 0);
    run_op(8'h5A, 8'h0F, 3'b001, 1'b0);

    // Reset wins over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_vs_start", busy, 0);
    step();
    check("rst_vs_start2", busy, 0);

    // Randomized operations.
    for (int k = 0; k < 24; k++) begin
      run_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
    end

    // Start held high: back-to-back operations, one done every WIDTH+2 cycles.
    a_in      = 8'h01;
    b_in      = 8'h01;
    op        = 3'b001;
    start     = 1'b1;
    last_done = -1;
    n_done    = 0;
    step();
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        n_done++;
        check("b2b_result", result, 8'h01);
        if (last_done >= 0) check("b2b_gap", c - last_done, W + 2);
        last_done = c;
      end
      step();
    end
    start = 1'b0;
    check("b2b_count", n_done, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  3  operation code, forwarded unmodified to the 1-bit slice as alu_o.
REQ-006 a_in  input  WIDTH  operand A, captured on accepted start.
REQ-007 b_in  input  WIDTH  operand B, captured on accepted start.
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 result  output  WIDTH  assembled result, LSB = first slice output.
REQ-011 alu_a  output  1  operand bit to slice.
REQ-012 alu_b  output  1  operand bit to slice.
REQ-013 alu_o  output  3  opcode to slice (drives its o1/o2/o3 as alu_o[2]/[1]/[0]).
REQ-014 alu_c  input  1  combinational slice output for the current alu_a/alu_b/alu_o.
REQ-015 zero  output  1  result-is-zero flag; present only with SERIAL_ALU_ZERO_EN.

Function
REQ-016 FSM states: IDLE, RUN, DONE; encoding free.
REQ-017 IDLE & start=1: capture a_in, b_in, op into a_sh, b_sh, op_q; clear bit counter; clear result; go RUN.
REQ-018 IDLE & start=0: hold all state; result keeps last value.
REQ-019 RUN: alu_a=a_sh[0], alu_b=b_sh[0], alu_o=op_q, all combinational from registers.
REQ-020 RUN, each cycle: result <= {alu_c, result[WIDTH-1:1]}; a_sh, b_sh shift right by one (zero fill); counter increments.
REQ-021 RUN lasts exactly WIDTH cycles; on the cycle counter==WIDTH-1, next state DONE.
REQ-022 DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-023 Latency: start accepted at edge N -> done high during cycle N+WIDTH+1 -> busy low from N+WIDTH+2.
REQ-024 start while busy (RUN or DONE) is ignored; no queuing; operands not recaptured.
REQ-025 Outside RUN: alu_a=0, alu_b=0, alu_o=3'b000.
REQ-026 op, a_in, b_in changes during RUN have no effect on the in-flight operation.
REQ-027 result is stable from DONE until the next accepted start.
REQ-028 Counter width = clog2(WIDTH)+1; no wrap inside a single operation.

Reset
REQ-029 rst=1 at a clock edge forces IDLE in any state, including mid-RUN; the partial operation is discarded.
REQ-030 Reset values: busy=0, done=0, result=0, a_sh=b_sh=0, op_q=0, counter=0, zero=1 (when present).
REQ-031 rst has priority over start in the same cycle.

Configuration
REQ-032 Macro SERIAL_ALU_ZERO_EN: when defined, port zero exists; a sticky OR register clears on accepted start, ORs alu_c each RUN cycle; zero = ~OR, valid from DONE, held until next start.
REQ-033 Without SERIAL_ALU_ZERO_EN: no zero port, no OR register; all other behaviour identical.

Verification (WIDTH=8; bench slice stub: alu_o=000 AND, 001 OR, 010 XOR, else alu_c=alu_a)
REQ-034 a_in=8'hF0, b_in=8'h3C, op=000, start 1 cycle -> alu_a sequence (LSB first) 0,0,0,0,1,1,1,1; done at cycle 9; result=8'h30; zero=0.
REQ-035 a_in=8'hAA, b_in=8'h55, op=010 -> result=8'hFF; op=000 on same operands -> result=8'h00, zero=1.
REQ-036 start pulsed again on cycles 3 and 9 of an operation (RUN and DONE) -> ignored; result unchanged; busy drops exactly at cycle 10.
REQ-037 rst asserted on cycle 4 of RUN -> next cycle busy=0, done=0, result=0, alu_a/alu_b/alu_o=0; new start afterwards completes normally in 9 cycles.
REQ-038 start held high continuously with a_in=8'h01, b_in=8'h01, op=001 -> back-to-back operations, each result=8'h01, one done pulse per 10 cycles.
REQ-039 Build without SERIAL_ALU_ZERO_EN -> REQ-034/035 results and timing unchanged; zero port absent.
